// File: rtl/lemmings_pkg.sv
// Shared definitions for the lemmings bridge arbiter: heading constants and bridge states.
package lemmings_pkg;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    FLOW_LEFT,
    FLOW_RIGHT,
    DRAIN
  } bridge_state_e;

  function automatic bridge_state_e flow_state(input logic d);
    return (d == RIGHT) ? FLOW_RIGHT : FLOW_LEFT;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin picker; ptr_q holds the index where the next search starts.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt,
  output logic         found
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] win;
  logic [IW-1:0] idx;
  logic [IW:0]   sum;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    sum   = '0;
    for (int off = 0; off < N; off++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(off);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      idx = sum[IW-1:0];
      if (!found && req[idx]) begin
        found    = 1'b1;
        win      = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

  // The pointer only moves when the caller actually issues the grant.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (win == IW'(N-1)) ? '0 : win + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/lemmings_bridge_arbiter.sv
// Single-lane bridge arbiter: round-robin entry, per-walker crossing timers,
// and direction reversal only after the bridge has drained.
module lemmings_bridge_arbiter
  import lemmings_pkg::*;
#(
  parameter int N            = 4,
  parameter int CAP          = 2,
  parameter int CROSS_CYCLES = 4,
  parameter int MAX_RUN      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N-1:0]               req,
  input  logic [N-1:0]               dir,
  output logic [N-1:0]               grant,
  output logic                       bridge_dir,
  output logic [$clog2(CAP+1)-1:0]   occupancy,
  output logic                       busy
);

  localparam int OW = $clog2(CAP+1);
  localparam int TW = $clog2(CROSS_CYCLES+1);
  localparam int RW = $clog2(MAX_RUN+1);

  bridge_state_e state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          bridge_dir_q, bridge_dir_d;
  logic [RW-1:0] run_q, run_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [TW-1:0] timer_q [CAP];
  logic [TW-1:0] timer_d [CAP];

  logic [N-1:0]  elig;
  logic [N-1:0]  heading_match;
  logic [N-1:0]  same_mask;
  logic [N-1:0]  opp_mask;
  logic          any_elig;
  logic          any_same;
  logic          opp_wait;
  logic [N-1:0]  arb_req;
  logic [N-1:0]  arb_gnt;
  logic          arb_found;
  logic          grant_any;
  logic [OW-1:0] exit_cnt;
  logic          loaded;

  // A walker's req lags its grant by a cycle, so the live grant masks it out.
  assign elig          = req & ~grant_q;
  assign heading_match = (bridge_dir_q == RIGHT) ? dir : ~dir;
  assign same_mask     = elig & heading_match;
  assign opp_mask      = elig & ~heading_match;
  assign any_elig      = |elig;
  assign any_same      = |same_mask;
  assign opp_wait      = |opp_mask;
  assign grant_any     = |grant_d;

  always_comb begin
    arb_req = '0;
    case (state_q)
      IDLE:                  arb_req = elig;
      FLOW_LEFT, FLOW_RIGHT: arb_req = same_mask;
      default:               arb_req = '0;
    endcase
  end

  rr_arbiter #(
    .N(N)
  ) u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    (arb_req),
    .advance(grant_any),
    .gnt    (arb_gnt),
    .found  (arb_found)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = '0;
    bridge_dir_d = bridge_dir_q;
    run_d        = run_q;
    case (state_q)
      IDLE: begin
        run_d = '0;
        if (arb_found) begin
          grant_d      = arb_gnt;
          bridge_dir_d = |(arb_gnt & dir);
          state_d      = flow_state(|(arb_gnt & dir));
        end
      end
      FLOW_LEFT, FLOW_RIGHT: begin
        if (!opp_wait) begin
          run_d = '0;
        end
        // Reversal decision takes priority and suppresses this cycle's grant.
        if (opp_wait && ((run_q == RW'(MAX_RUN)) || !any_same)) begin
          state_d = DRAIN;
        end else if (!any_elig && (occ_q == '0)) begin
          state_d = IDLE;
        end else if (arb_found && (occ_q < OW'(CAP))) begin
          grant_d = arb_gnt;
          if (opp_wait) begin
            run_d = run_q + RW'(1);
          end
        end
      end
      DRAIN: begin
        if (occ_q == '0) begin
          if (any_elig) begin
            bridge_dir_d = ~bridge_dir_q;
            run_d        = '0;
            state_d      = flow_state(~bridge_dir_q);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Occupancy always equals the number of nonzero timers.
  always_comb begin
    timer_d  = timer_q;
    exit_cnt = '0;
    loaded   = 1'b0;
    for (int i = 0; i < CAP; i++) begin
      if (timer_q[i] != '0) begin
        timer_d[i] = timer_q[i] - TW'(1);
      end
      if (timer_q[i] == TW'(1)) begin
        exit_cnt = exit_cnt + OW'(1);
      end
    end
    for (int i = 0; i < CAP; i++) begin
      if (grant_any && !loaded && (timer_q[i] == '0)) begin
        timer_d[i] = TW'(CROSS_CYCLES);
        loaded     = 1'b1;
      end
    end
    occ_d = occ_q + OW'(grant_any) - exit_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      bridge_dir_q <= LEFT;
      run_q        <= '0;
      occ_q        <= '0;
      for (int i = 0; i < CAP; i++) begin
        timer_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      bridge_dir_q <= bridge_dir_d;
      run_q        <= run_d;
      occ_q        <= occ_d;
      timer_q      <= timer_d;
    end
  end

  assign grant      = grant_q;
  assign bridge_dir = bridge_dir_q;
  assign occupancy  = occ_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_lemmings_bridge_arbiter.sv
// Directed self-checking bench for lemmings_bridge_arbiter (N=4, CAP=2, CROSS_CYCLES=4, MAX_RUN=4).
module tb_lemmings_bridge_arbiter;

  localparam int N            = 4;
  localparam int CAP          = 2;
  localparam int CROSS_CYCLES = 4;
  localparam int MAX_RUN      = 4;
  localparam int OW           = $clog2(CAP+1);

  // Hand-derived schedule for the fairness run, one entry per edge E1..E17.
  localparam logic [3:0] FAIR_GRANT [17] = '{
    4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0001, 4'b0000, 4'b0000,
    4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000
  };
  localparam int FAIR_OCC [17] = '{1, 2, 2, 2, 1, 1, 2, 2, 2, 1, 1, 1, 1, 1, 0, 0, 1};

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N-1:0]  dir;
  logic [N-1:0]  grant;
  logic          bridge_dir;
  logic [OW-1:0] occupancy;
  logic          busy;

  int compare_count  = 0;
  int mismatch_count = 0;

  lemmings_bridge_arbiter #(
    .N           (N),
    .CAP         (CAP),
    .CROSS_CYCLES(CROSS_CYCLES),
    .MAX_RUN     (MAX_RUN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .dir       (dir),
    .grant     (grant),
    .bridge_dir(bridge_dir),
    .occupancy (occupancy),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] d);
    req = r;
    dir = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compare_count++;
    if (actual !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus('0, '0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values, then a single RIGHT walker crossing alone.
    doReset();
    checkOutput("reset grant", 32'(grant), 32'h0);
    checkOutput("reset occupancy", 32'(occupancy), 32'h0);
    checkOutput("reset bridge_dir", 32'(bridge_dir), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);

    applyStimulus(4'b0001, 4'b0001);
    tick();
    checkOutput("single grant", 32'(grant), 32'b0001);
    checkOutput("single bridge_dir", 32'(bridge_dir), 32'h1);
    checkOutput("single occ c1", 32'(occupancy), 32'h1);
    checkOutput("single busy", 32'(busy), 32'h1);
    tick();
    checkOutput("single no regrant", 32'(grant), 32'h0);
    checkOutput("single occ c2", 32'(occupancy), 32'h1);
    applyStimulus('0, '0);
    tick();
    checkOutput("single occ c3", 32'(occupancy), 32'h1);
    tick();
    checkOutput("single occ c4", 32'(occupancy), 32'h1);
    tick();
    checkOutput("single occ exit", 32'(occupancy), 32'h0);
    tick();
    checkOutput("single idle busy", 32'(busy), 32'h0);
    checkOutput("single idle dir kept", 32'(bridge_dir), 32'h1);

    // Capacity limit, followed by a round-robin wrap after a grant to index 3.
    doReset();
    applyStimulus(4'b1111, 4'b0000);
    tick();
    checkOutput("cap E1 grant", 32'(grant), 32'b0001);
    checkOutput("cap E1 occ", 32'(occupancy), 32'h1);
    checkOutput("cap E1 dir", 32'(bridge_dir), 32'h0);
    tick();
    checkOutput("cap E2 grant", 32'(grant), 32'b0010);
    checkOutput("cap E2 occ", 32'(occupancy), 32'h2);
    applyStimulus(4'b1110, 4'b0000);
    tick();
    checkOutput("cap E3 grant", 32'(grant), 32'h0);
    checkOutput("cap E3 occ", 32'(occupancy), 32'h2);
    applyStimulus(4'b1100, 4'b0000);
    tick();
    checkOutput("cap E4 grant", 32'(grant), 32'h0);
    checkOutput("cap E4 occ", 32'(occupancy), 32'h2);
    tick();
    checkOutput("cap E5 grant", 32'(grant), 32'h0);
    checkOutput("cap E5 occ", 32'(occupancy), 32'h1);
    tick();
    checkOutput("cap E6 grant", 32'(grant), 32'b0100);
    checkOutput("cap E6 occ", 32'(occupancy), 32'h1);
    tick();
    checkOutput("cap E7 grant", 32'(grant), 32'b1000);
    checkOutput("cap E7 occ", 32'(occupancy), 32'h2);
    applyStimulus(4'b1000, 4'b0000);
    tick();
    checkOutput("wrap E8 grant", 32'(grant), 32'h0);
    applyStimulus(4'b1001, 4'b0000);
    tick();
    checkOutput("wrap E9 grant", 32'(grant), 32'h0);
    checkOutput("wrap E9 occ", 32'(occupancy), 32'h2);
    tick();
    checkOutput("wrap E10 occ", 32'(occupancy), 32'h1);
    tick();
    checkOutput("wrap first grant", 32'(grant), 32'b0001);
    tick();
    checkOutput("wrap second grant", 32'(grant), 32'b1000);
    applyStimulus('0, '0);

    // Fairness: LEFT walkers keep requesting while walker 3 waits to go RIGHT.
    doReset();
    applyStimulus(4'b0001, 4'b1000);
    for (int i = 0; i < 17; i++) begin
      tick();
      if (i == 0) begin
        applyStimulus(4'b1111, 4'b1000);
      end
      checkOutput($sformatf("fair E%0d grant", i + 1), 32'(grant), 32'(FAIR_GRANT[i]));
      checkOutput($sformatf("fair E%0d occ", i + 1), 32'(occupancy), 32'(FAIR_OCC[i]));
      checkOutput($sformatf("fair E%0d dir", i + 1), 32'(bridge_dir), (i >= 15) ? 32'h1 : 32'h0);
    end
    applyStimulus('0, '0);

    // Only an opposite-direction walker pending: drain straight away.
    doReset();
    applyStimulus(4'b0001, 4'b0000);
    tick();
    checkOutput("opp E1 grant", 32'(grant), 32'b0001);
    applyStimulus(4'b0101, 4'b0100);
    tick();
    checkOutput("opp E2 grant", 32'(grant), 32'h0);
    checkOutput("opp E2 occ", 32'(occupancy), 32'h1);
    checkOutput("opp E2 busy", 32'(busy), 32'h1);
    applyStimulus(4'b0100, 4'b0100);
    tick();
    checkOutput("opp E3 grant", 32'(grant), 32'h0);
    tick();
    tick();
    checkOutput("opp E5 occ", 32'(occupancy), 32'h0);
    checkOutput("opp E5 dir", 32'(bridge_dir), 32'h0);
    tick();
    checkOutput("opp E6 dir", 32'(bridge_dir), 32'h1);
    checkOutput("opp E6 grant", 32'(grant), 32'h0);
    tick();
    checkOutput("opp E7 grant", 32'(grant), 32'b0100);
    checkOutput("opp E7 occ", 32'(occupancy), 32'h1);
    checkOutput("opp E7 dir", 32'(bridge_dir), 32'h1);
    applyStimulus('0, '0);

    // Reset while two walkers are on a RIGHT-flowing bridge.
    doReset();
    applyStimulus(4'b0011, 4'b0011);
    tick();
    checkOutput("rst E1 grant", 32'(grant), 32'b0001);
    tick();
    checkOutput("rst E2 grant", 32'(grant), 32'b0010);
    checkOutput("rst E2 occ", 32'(occupancy), 32'h2);
    checkOutput("rst E2 dir", 32'(bridge_dir), 32'h1);
    reset = 1'b1;
    tick();
    checkOutput("rst occ", 32'(occupancy), 32'h0);
    checkOutput("rst grant", 32'(grant), 32'h0);
    checkOutput("rst dir", 32'(bridge_dir), 32'h0);
    checkOutput("rst busy", 32'(busy), 32'h0);
    reset = 1'b0;
    applyStimulus('0, '0);
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    checkOutput("rst later occ", 32'(occupancy), 32'h0);
    checkOutput("rst later busy", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
